// File: rtl/ser_pkg.sv
// Shared types and constants for the bit serializer feeding the 1011 detector.
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam int SER_DEFAULT_WIDTH = 8;

  function automatic int ser_cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-in/serial-out stage with a one-word holding register; MSB first
// by default, LSB first when SER_LSB_FIRST_EN is defined.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int   WIDTH    = SER_DEFAULT_WIDTH,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int             CW   = ser_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             x_out_q, x_out_d;
  logic             x_valid_q, x_valid_d;
  logic             word_done_q, word_done_d;
  logic             busy_q, busy_d;
  logic             xfer;

  assign in_ready  = ~hold_full_q;
  assign xfer      = in_valid & ~hold_full_q;
  assign x_out     = x_out_q;
  assign x_valid   = x_valid_q;
  assign word_done = word_done_q;
  assign busy      = busy_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          shift_d = in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          // Held word wins over a new transfer; the two never coincide anyway.
          cnt_d = '0;
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
          end else if (xfer) begin
            shift_d = in_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
`ifdef SER_LSB_FIRST_EN
          shift_d = {1'b0, shift_q[WIDTH-1:1]};
`else
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
`endif
          cnt_d = cnt_q + CW'(1);
          if (xfer) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the next-state values.
    x_valid_d   = (state_d == SHIFT);
    word_done_d = (state_d == SHIFT) && (cnt_d == LAST);
    busy_d      = (state_d == SHIFT) || hold_full_d;
`ifdef SER_LSB_FIRST_EN
    x_out_d = (state_d == SHIFT) ? shift_d[0] : IDLE_BIT;
`else
    x_out_d = (state_d == SHIFT) ? shift_d[WIDTH-1] : IDLE_BIT;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      x_out_q     <= IDLE_BIT;
      x_valid_q   <= 1'b0;
      word_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      x_out_q     <= x_out_d;
      x_valid_q   <= x_valid_d;
      word_done_q <= word_done_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: a bit-queue reference model checked
// every cycle, plus directed sequences with literal expectations.
module tb_bit_serializer;

  localparam int   W      = 4;
  localparam logic IDLE_V = 1'b0;

`ifdef SER_LSB_FIRST_EN
  localparam logic [W-1:0] PIN_A = 4'b1101;
  localparam logic [W-1:0] PIN_C = 4'b1100;
`else
  localparam logic [W-1:0] PIN_A = 4'b1011;
  localparam logic [W-1:0] PIN_C = 4'b0011;
`endif
  localparam logic [W-1:0] PIN_B = 4'b0110;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready, x_out, x_valid, word_done, busy;

  int checks = 0;
  int errors = 0;

  bit_serializer #(.WIDTH(W), .IDLE_BIT(IDLE_V)) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .x_out(x_out),
    .x_valid(x_valid),
    .word_done(word_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: bits still to appear on the serial line, and accepted
  // words that have not started yet.
  bit           m_live = 1'b0;
  bit           m_take;
  bit           bitq[$];
  logic [W-1:0] pend[$];
  logic         e_x, e_v, e_d, e_busy, e_ready;

  function automatic void push_word(input logic [W-1:0] w);
`ifdef SER_LSB_FIRST_EN
    for (int i = 0; i < W; i++) bitq.push_back(w[i]);
`else
    for (int i = W - 1; i >= 0; i--) bitq.push_back(w[i]);
`endif
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      bitq.delete();
      pend.delete();
      m_live = 1'b1;
    end else if (m_live) begin
      m_take = in_valid && (pend.size() == 0);
      if (bitq.size() > 0) void'(bitq.pop_front());
      if (m_take) pend.push_back(in_data);
      if (bitq.size() == 0 && pend.size() > 0) push_word(pend.pop_front());
    end
    e_x     = (bitq.size() > 0) ? bitq[0] : IDLE_V;
    e_v     = (bitq.size() > 0);
    e_d     = (bitq.size() == 1);
    e_busy  = (bitq.size() > 0) || (pend.size() > 0);
    e_ready = (pend.size() == 0);
  end

  task automatic checkOutput(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] d);
    in_valid = v;
    in_data  = d;
  endtask

  // Model comparison on every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_live) begin
      checkOutput("model_x_out", x_out, e_x);
      checkOutput("model_x_valid", x_valid, e_v);
      checkOutput("model_word_done", word_done, e_d);
      checkOutput("model_busy", busy, e_busy);
      checkOutput("model_in_ready", in_ready, e_ready);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [0:5] sx, sv, sd;
    logic [0:8] bx, bv, bd;
    logic [0:3] cx, cd;

    sx = 6'b101100; sv = 6'b111100; sd = 6'b000100;
    bx = 9'b101101100; bv = 9'b111111110; bd = 9'b000100010;
    cx = 4'b0011; cd = 4'b0001;

    applyStimulus(1'b0, '0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_x_out", x_out, 1'b0);
    checkOutput("rst_x_valid", x_valid, 1'b0);
    checkOutput("rst_word_done", word_done, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    reset = 1'b1;

    // Idle fill.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("idle_x_out", x_out, 1'b0);
      checkOutput("idle_x_valid", x_valid, 1'b0);
      checkOutput("idle_word_done", word_done, 1'b0);
    end

    // Single word: bits 1,0,1,1 then idle.
    applyStimulus(1'b1, PIN_A);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) applyStimulus(1'b0, '0);
      checkOutput("single_x_out", x_out, sx[k]);
      checkOutput("single_x_valid", x_valid, sv[k]);
      checkOutput("single_word_done", word_done, sd[k]);
    end

    // Back-to-back words with no gap.
    applyStimulus(1'b1, PIN_A);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 0) applyStimulus(1'b1, PIN_B);
      else if (k == 1) applyStimulus(1'b0, '0);
      checkOutput("b2b_x_out", x_out, bx[k]);
      checkOutput("b2b_x_valid", x_valid, bv[k]);
      checkOutput("b2b_word_done", word_done, bd[k]);
    end
    repeat (2) @(negedge clk);

    // Backpressure with three words offered continuously.
    applyStimulus(1'b1, 4'h9);
    @(negedge clk);
    applyStimulus(1'b1, 4'h3);
    @(negedge clk);
    applyStimulus(1'b1, 4'hE);
    checkOutput("bp_ready_c2", in_ready, 1'b0);
    @(negedge clk);
    checkOutput("bp_ready_c3", in_ready, 1'b0);
    @(negedge clk);
    checkOutput("bp_ready_c4", in_ready, 1'b0);
    @(negedge clk);
    checkOutput("bp_ready_c5", in_ready, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, '0);
    checkOutput("bp_ready_c6", in_ready, 1'b0);
    repeat (12) @(negedge clk);

    // Reset in the middle of a word with the holding register full.
    applyStimulus(1'b1, 4'b1010);
    @(negedge clk);
    applyStimulus(1'b1, 4'b0101);
    @(negedge clk);
    applyStimulus(1'b0, '0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("midrst_x_valid", x_valid, 1'b0);
    checkOutput("midrst_in_ready", in_ready, 1'b1);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_x_out", x_out, 1'b0);
    applyStimulus(1'b1, PIN_C);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) applyStimulus(1'b0, '0);
      checkOutput("post_rst_x_out", x_out, cx[k]);
      checkOutput("post_rst_word_done", word_done, cd[k]);
    end
    repeat (3) @(negedge clk);

    // Randomized traffic with occasional resets, checked by the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) != 0);
      if (n < 1500) in_valid = ($urandom_range(0, 3) != 0);
      else in_valid = ($urandom_range(0, 3) == 0);
      in_data = W'($urandom);
    end
    applyStimulus(1'b0, '0);
    reset = 1'b1;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
